// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared constants and state encoding for the FIFO write-side producer
package shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int DRAIN_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DRAIN,
        DONE
    } writer_state_e;

endpackage

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - pattern register, incrementing or Galois LFSR, mode latched on load
module pattern_gen #(
    parameter int WIDTH = shared_pkg::FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] pattern
);
    import shared_pkg::*;

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);

    logic             mode_q;
    logic [WIDTH-1:0] next_pattern;

    always_comb begin
        next_pattern = pattern + WIDTH'(1);
        if (mode_q) begin
            next_pattern = (pattern >> 1) ^ (pattern[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= '0;
            mode_q  <= 1'b0;
        end else if (load) begin
            mode_q <= mode;
            // an all-zero LFSR state would lock up, so it is replaced by 1
            pattern <= (mode && seed == '0) ? WIDTH'(1) : seed;
        end else if (advance) begin
            pattern <= next_pattern;
        end
    end

endmodule

// File: rtl/fifo_burst_writer.sv
// rtl/fifo_burst_writer.sv - burst producer for the sync FIFO write port; FIFO_WR_THROTTLE_EN stops at almostfull
module fifo_burst_writer #(
    parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic [FIFO_WIDTH-1:0] seed,
    input  logic                  mode,
    input  logic                  full,
    input  logic                  almostfull,
    input  logic                  wr_ack,
    input  logic                  overflow,
    output logic                  wr_en,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      words_sent,
    output logic [LEN_W-1:0]      ack_count,
    output logic                  err_overflow,
    output logic                  err_ack_mismatch
);
    import shared_pkg::*;

    writer_state_e    state_q, state_d;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] ack_next;
    logic [2:0]       drain_cnt;
    logic             load;

    assign busy     = (state_q == WRITE) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    // count the ack arriving this cycle so a clean burst leaves DRAIN immediately
    assign ack_next = ack_count + LEN_W'(wr_ack && busy);

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = (burst_len != '0);
                    state_d = (burst_len != '0) ? WRITE : DONE;
                end
            end
            WRITE: begin
`ifdef FIFO_WR_THROTTLE_EN
                wr_en = !full && !almostfull;
`else
                wr_en = !full;
`endif
                if (wr_en && remaining == LEN_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ack_next == words_sent || drain_cnt == 3'(DRAIN_TIMEOUT - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            remaining        <= '0;
            words_sent       <= '0;
            ack_count        <= '0;
            err_overflow     <= 1'b0;
            err_ack_mismatch <= 1'b0;
            drain_cnt        <= '0;
        end else begin
            state_q   <= state_d;
            drain_cnt <= (state_q == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
            if (load) begin
                remaining        <= burst_len;
                words_sent       <= '0;
                ack_count        <= '0;
                err_overflow     <= 1'b0;
                err_ack_mismatch <= 1'b0;
            end else begin
                if (wr_en) begin
                    remaining  <= remaining - LEN_W'(1);
                    words_sent <= words_sent + LEN_W'(1);
                end
                if (busy && wr_ack) begin
                    ack_count <= ack_count + LEN_W'(1);
                end
                if (busy && overflow) begin
                    err_overflow <= 1'b1;
                end
                if (state_q == DRAIN && state_d == DONE && ack_next != words_sent) begin
                    err_ack_mismatch <= 1'b1;
                end
            end
        end
    end

    pattern_gen #(
        .WIDTH(FIFO_WIDTH)
    ) u_pattern_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .advance(wr_en),
        .mode   (mode),
        .seed   (seed),
        .pattern(data_in)
    );

endmodule

// File: tb/tb_fifo_burst_writer.sv
// tb/tb_fifo_burst_writer.sv - randomized scoreboard bench with a depth-8 FIFO model
module tb_fifo_burst_writer;

    localparam int W     = 16;
    localparam int L     = 8;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst, start, mode;
    logic         full, almostfull, wr_ack, overflow;
    logic         wr_en, busy, done, err_overflow, err_ack_mismatch;
    logic [L-1:0] burst_len, words_sent, ack_count;
    logic [W-1:0] seed, data_in;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_burst_writer #(.FIFO_WIDTH(W), .LEN_W(L)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .burst_len       (burst_len),
        .seed            (seed),
        .mode            (mode),
        .full            (full),
        .almostfull      (almostfull),
        .wr_ack          (wr_ack),
        .overflow        (overflow),
        .wr_en           (wr_en),
        .data_in         (data_in),
        .busy            (busy),
        .done            (done),
        .words_sent      (words_sent),
        .ack_count       (ack_count),
        .err_overflow    (err_overflow),
        .err_ack_mismatch(err_ack_mismatch)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    // FIFO model: one response per write on the following cycle
    int   fcount    = 0;
    int   total_wr  = 0;
    int   inject_at = -1;
    int   rd_mode   = 1;
    int   cyc       = 0;
    logic rd_coin   = 1'b0;
    logic do_rd, do_wr, do_ovf;

    assign full       = (fcount == DEPTH);
    assign almostfull = (fcount >= DEPTH - 1);

    always_comb begin
        do_rd  = (fcount > 0) && (rd_mode == 1 || (rd_mode == 2 && rd_coin));
        do_ovf = wr_en && (full || total_wr == inject_at);
        do_wr  = wr_en && !do_ovf;
    end

    always @(negedge clk) rd_coin <= 1'($urandom_range(1, 0));
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            fcount   <= 0;
            total_wr <= 0;
            wr_ack   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            fcount   <= fcount + int'(do_wr) - int'(do_rd);
            total_wr <= total_wr + int'(wr_en);
            wr_ack   <= do_wr;
            overflow <= do_ovf;
        end
    end

    // scoreboard
    typedef struct {
        bit     chk_counts;
        int     ws;
        int     ac;
        int     eo;
        int     em;
        int     lat;
    } done_t;

    logic [W-1:0] exp_q[$];
    done_t        done_q[$];
    int           last_wr_cyc = 0;
    int           seen_wr     = 0;
    int           done_seen   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr_en", 1, 0);
                end else begin
                    chk("data_in", int'(data_in), int'(exp_q.pop_front()));
                end
                last_wr_cyc = cyc;
                seen_wr++;
            end else if (busy && exp_q.size() != 0) begin
                chk("stall_data_in", int'(data_in), int'(exp_q[0]));
            end
            if (done) begin
                done_seen++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    if (d.lat >= 0) chk("done_latency", cyc - last_wr_cyc, d.lat);
                    if (d.chk_counts) begin
                        chk("words_sent", int'(words_sent), d.ws);
                        chk("ack_count", int'(ack_count), d.ac);
                        chk("err_overflow", int'(err_overflow), d.eo);
                        chk("err_ack_mismatch", int'(err_ack_mismatch), d.em);
                    end
                end
            end
        end
    end

    function automatic logic [W-1:0] ref_next(input logic [W-1:0] p, input bit md);
        if (md) return (p >> 1) ^ (((p % 2) == 1) ? 16'hB400 : 16'h0000);
        return p + 16'd1;
    endfunction

    task automatic burst(input int len, input logic [W-1:0] sd, input bit md, input int ovf_word);
        logic [W-1:0] p;
        done_t        d;
        p = (md && sd == 0) ? 16'h0001 : sd;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(p);
            p = ref_next(p, md);
        end
        d.chk_counts = (len != 0);
        d.ws         = len;
        d.ac         = (ovf_word >= 0) ? len - 1 : len;
        d.eo         = (ovf_word >= 0) ? 1 : 0;
        d.em         = (ovf_word >= 0) ? 1 : 0;
        d.lat        = (len == 0) ? -1 : ((ovf_word >= 0) ? 5 : 2);
        done_q.push_back(d);
        @(posedge clk);
        #1;
        start     = 1'b1;
        burst_len = L'(len);
        seed      = sd;
        mode      = md;
        inject_at = (ovf_word >= 0) ? total_wr + ovf_word : -1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (len == 0) begin
            chk("zero_len_done", int'(done), 1);
            chk("zero_len_wr_en", int'(wr_en), 0);
        end else begin
            chk("start_words_sent", int'(words_sent), 0);
            chk("start_err_overflow", int'(err_overflow), 0);
            chk("start_err_mismatch", int'(err_ack_mismatch), 0);
        end
    endtask

    task automatic wait_done();
        int n0;
        n0 = done_seen;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_seen > n0) break;
        end
        #1;
        if (done_seen == n0) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_empty();
        rd_mode = 1;
        for (int i = 0; i < 50 && fcount != 0; i++) @(posedge clk);
        #1;
        chk("fifo_drained", fcount, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_words_sent"}, int'(words_sent), 0);
        chk({tag, "_ack_count"}, int'(ack_count), 0);
        chk({tag, "_err_overflow"}, int'(err_overflow), 0);
        chk({tag, "_err_mismatch"}, int'(err_ack_mismatch), 0);
        chk({tag, "_data_in"}, int'(data_in), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst       = 1'b1;
        start     = 1'b0;
        burst_len = '0;
        seed      = '0;
        mode      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        burst(5, 16'h00F0, 1'b0, -1);
        wait_done();

        burst(0, 16'h1111, 1'b0, -1);
        wait_done();

        burst(6, 16'h0000, 1'b1, -1);
        wait_done();

        wait_empty();
        rd_mode = 0;
        burst(12, 16'($urandom), 1'b0, -1);
        repeat (20) @(posedge clk);
        #1;
`ifdef FIFO_WR_THROTTLE_EN
        chk("bp_words_sent", int'(words_sent), DEPTH - 1);
`else
        chk("bp_words_sent", int'(words_sent), DEPTH);
`endif
        chk("bp_wr_en", int'(wr_en), 0);
        chk("bp_busy", int'(busy), 1);
        rd_mode = 1;
        wait_done();

        wait_empty();
        burst(6, 16'h1234, 1'b0, 2);
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        chk("sticky_err_overflow", int'(err_overflow), 1);
        chk("sticky_err_mismatch", int'(err_ack_mismatch), 1);
        burst(3, 16'hFFFE, 1'b0, -1);
        wait_done();

        for (int i = 0; i < 8; i++) begin
            rd_mode = 2;
            burst($urandom_range(20, 1), 16'($urandom), 1'($urandom_range(1, 0)), -1);
            wait_done();
        end

        wait_empty();
        s0 = seen_wr;
        burst(8, 16'h0500, 1'b0, -1);
        for (int i = 0; i < 50 && seen_wr - s0 < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("midburst_reset");
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        s0  = done_seen;
        repeat (6) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_seen - s0, 0);

        burst(4, 16'hABCD, 1'b1, -1);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_words_left", exp_q.size(), 0);
        chk("scoreboard_done_left", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
